// File: rtl/pe_pkg.sv
// Shared definitions for the systolic-array processing element: FSM state
// encoding and default datapath widths.
package pe_pkg;

  localparam int DEFAULT_ACC_W = 80;
  localparam int DEFAULT_K_W   = 16;
  localparam int PRODUCT_W     = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/k_counter.sv
// Down-counter of products still owed to the current dot product.
// Loads on start and steps down once per accepted product.
module k_counter #(
  parameter int K_W = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           load,
  input  logic [K_W-1:0] load_val,
  input  logic           dec,
  output logic [K_W-1:0] remaining,
  output logic           last,
  output logic           zero
);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (reset) begin
      remaining <= '0;
    end else if (load) begin
      remaining <= load_val;
    end else if (dec && !zero) begin
      remaining <= remaining - K_W'(1);
    end
  end

  assign last = (remaining == K_W'(1));
  assign zero = (remaining == '0);

endmodule

// File: rtl/mac_accumulator.sv
// Sums exactly k_len unsigned 64-bit products into a wide accumulator and
// pulses acc_done for one cycle with the registered result on acc_out.
module mac_accumulator
  import pe_pkg::*;
#(
  parameter int ACC_W = DEFAULT_ACC_W,
  parameter int K_W   = DEFAULT_K_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [K_W-1:0]       k_len,
  input  logic [PRODUCT_W-1:0] product,
  input  logic                 prod_valid,
  output logic [ACC_W-1:0]     acc_out,
  output logic                 acc_done,
  output logic                 busy,
  output logic                 overflow,
  output logic                 stray
);

  state_e           state;
  state_e           state_nxt;
  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   sum;
  logic [K_W-1:0]   remaining;
  logic             accept;
  logic             last;
  logic             zero;

  // A product arriving alongside start belongs to no run and is dropped.
  assign accept = (state == ST_ACCUM) && prod_valid && !start && !zero;

  k_counter #(.K_W(K_W)) u_k_counter (
    .clk       (clk),
    .reset     (reset),
    .load      (start),
    .load_val  (k_len),
    .dec       (accept),
    .remaining (remaining),
    .last      (last),
    .zero      (zero)
  );

  // One extra bit on the sum exposes the carry out of the accumulator.
  assign sum = {1'b0, acc} + {{(ACC_W + 1 - PRODUCT_W){1'b0}}, product};

  // NOTE: next state gets a default before any branch so no latch is inferred.
  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = (k_len == '0) ? ST_DONE : ST_ACCUM;
    end else begin
      case (state)
        ST_ACCUM: if (accept && last) state_nxt = ST_DONE;
        ST_DONE:  state_nxt = ST_IDLE;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      acc      <= '0;
      busy     <= 1'b0;
      acc_done <= 1'b0;
      overflow <= 1'b0;
      stray    <= 1'b0;
    end else begin
      state    <= state_nxt;
      busy     <= (state_nxt == ST_ACCUM);
      acc_done <= (state_nxt == ST_DONE);
      if (start) begin
        acc      <= '0;
        overflow <= 1'b0;
        stray    <= 1'b0;
      end else begin
        if (accept) begin
          acc <= sum[ACC_W-1:0];
          if (sum[ACC_W]) overflow <= 1'b1;
        end
        if (prod_valid && state != ST_ACCUM) stray <= 1'b1;
      end
    end
  end

  assign acc_out = acc;

endmodule

// File: tb/tb_mac_accumulator.sv
// Bench for mac_accumulator: an 80-bit and a 64-bit instance share stimulus;
// a sum-of-products model is compared every cycle, plus literal spot checks.
module tb_mac_accumulator;

  localparam int K_W = 16;
  localparam logic [63:0] ALL_ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] HALF     = 64'h8000_0000_0000_0000;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [K_W-1:0] k_len;
  logic [63:0]    product;
  logic           prod_valid;

  logic [79:0] acc_out_a;
  logic        done_a, busy_a, ovf_a, stray_a;
  logic [63:0] acc_out_b;
  logic        done_b, busy_b, ovf_b, stray_b;

  int total_n = 0;
  int bad_n   = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  mac_accumulator #(.ACC_W(80), .K_W(K_W)) dut_a (
    .clk(clk), .reset(reset), .start(start), .k_len(k_len),
    .product(product), .prod_valid(prod_valid),
    .acc_out(acc_out_a), .acc_done(done_a), .busy(busy_a),
    .overflow(ovf_a), .stray(stray_a)
  );

  mac_accumulator #(.ACC_W(64), .K_W(K_W)) dut_b (
    .clk(clk), .reset(reset), .start(start), .k_len(k_len),
    .product(product), .prod_valid(prod_valid),
    .acc_out(acc_out_b), .acc_done(done_b), .busy(busy_b),
    .overflow(ovf_b), .stray(stray_b)
  );

  task automatic check(input string name, input logic [127:0] actual,
                       input logic [127:0] expected);
    total_n++;
    if (actual !== expected) begin
      bad_n++;
      $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Model: the exact mathematical sum of the run's products. Each instance's
  // result is that sum modulo its width, and overflow means the sum reached
  // 2^width (sums only grow, so some addition must have carried).
  logic [95:0] m_total;
  logic        m_busy, m_done, m_stray;
  int          m_left;

  always @(posedge clk) begin
    if (reset) begin
      m_total <= '0; m_busy <= 1'b0; m_done <= 1'b0; m_stray <= 1'b0; m_left <= 0;
    end else if (start) begin
      m_total <= '0;
      m_stray <= 1'b0;
      m_left  <= int'(k_len);
      m_busy  <= (k_len != 0);
      m_done  <= (k_len == 0);
    end else if (m_busy) begin
      m_done <= 1'b0;
      if (prod_valid) begin
        m_total <= m_total + 96'(product);
        m_left  <= m_left - 1;
        if (m_left == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
        end
      end
    end else begin
      m_done <= 1'b0;
      if (prod_valid) m_stray <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      check("a.acc_out",  128'(acc_out_a), 128'(m_total[79:0]));
      check("a.overflow", 128'(ovf_a),     128'(|m_total[95:80]));
      check("a.acc_done", 128'(done_a),    128'(m_done));
      check("a.busy",     128'(busy_a),    128'(m_busy));
      check("a.stray",    128'(stray_a),   128'(m_stray));
      check("b.acc_out",  128'(acc_out_b), 128'(m_total[63:0]));
      check("b.overflow", 128'(ovf_b),     128'(|m_total[95:64]));
      check("b.acc_done", 128'(done_b),    128'(m_done));
      check("b.busy",     128'(busy_b),    128'(m_busy));
      check("b.stray",    128'(stray_b),   128'(m_stray));
    end
  end

  // Applies one cycle of inputs; on return the outputs reflect that edge.
  task automatic drive(input logic s, input logic [K_W-1:0] k,
                       input logic v, input logic [63:0] p);
    start = s; k_len = k; prod_valid = v; product = p;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; k_len = '0; prod_valid = 1'b0; product = '0;
    @(negedge clk);
    check_en = 1'b1;
    @(negedge clk);
    check("reset acc_out",  128'(acc_out_a), 128'(0));
    check("reset acc_done", 128'(done_a),    128'(0));
    check("reset busy",     128'(busy_a),    128'(0));
    check("reset stray",    128'(stray_a),   128'(0));
    reset = 1'b0;

    // Basic sum 1+2+3+4.
    drive(1'b1, 16'd4, 1'b0, 64'd0);
    drive(1'b0, 16'd0, 1'b1, 64'd1);
    drive(1'b0, 16'd0, 1'b1, 64'd2);
    drive(1'b0, 16'd0, 1'b1, 64'd3);
    check("basic early done", 128'(done_a), 128'(0));
    drive(1'b0, 16'd0, 1'b1, 64'd4);
    check("basic done",     128'(done_a),    128'(1));
    check("basic acc_out",  128'(acc_out_a), 128'(10));
    check("basic overflow", 128'(ovf_a),     128'(0));
    drive(1'b0, 16'd0, 1'b0, 64'd0);
    check("basic hold",     128'(acc_out_a), 128'(10));

    // Zero length.
    drive(1'b1, 16'd0, 1'b0, 64'd0);
    check("zero done",    128'(done_a),    128'(1));
    check("zero acc_out", 128'(acc_out_a), 128'(0));
    check("zero busy",    128'(busy_a),    128'(0));
    drive(1'b0, 16'd0, 1'b0, 64'd0);
    check("zero busy after", 128'(busy_a), 128'(0));

    // Gapped input, three all-ones products at cycles 1, 4, 9.
    drive(1'b1, 16'd3, 1'b0, 64'd0);
    check("gap busy c1", 128'(busy_a), 128'(1));
    for (int c = 1; c <= 9; c++) begin
      if (c == 1 || c == 4 || c == 9) drive(1'b0, 16'd0, 1'b1, ALL_ONES);
      else                            drive(1'b0, 16'd0, 1'b0, 64'd0);
      if (c < 9) begin
        check("gap busy", 128'(busy_a), 128'(1));
        check("gap done", 128'(done_a), 128'(0));
      end
    end
    check("gap final done", 128'(done_a),    128'(1));
    check("gap final busy", 128'(busy_a),    128'(0));
    check("gap acc_out",    128'(acc_out_a), 128'(80'h2_FFFF_FFFF_FFFF_FFFD));
    drive(1'b0, 16'd0, 1'b0, 64'd0);

    // Overflow on the 64-bit instance: 2^63 + 2^63.
    drive(1'b1, 16'd2, 1'b0, 64'd0);
    drive(1'b0, 16'd0, 1'b1, HALF);
    drive(1'b0, 16'd0, 1'b1, HALF);
    check("ovf64 done",     128'(done_b),    128'(1));
    check("ovf64 acc_out",  128'(acc_out_b), 128'(0));
    check("ovf64 overflow", 128'(ovf_b),     128'(1));
    check("ovf80 acc_out",  128'(acc_out_a), 128'(80'h1_0000_0000_0000_0000));
    check("ovf80 overflow", 128'(ovf_a),     128'(0));
    drive(1'b0, 16'd0, 1'b0, 64'd0);
    check("ovf64 sticky",   128'(ovf_b),     128'(1));

    // Abort after two products, restart with k_len=1; the product that
    // arrives with the restart is ignored.
    drive(1'b1, 16'd5, 1'b0, 64'd0);
    drive(1'b0, 16'd0, 1'b1, 64'd100);
    check("abort no done 1", 128'(done_a), 128'(0));
    drive(1'b0, 16'd0, 1'b1, 64'd200);
    check("abort no done 2", 128'(done_a), 128'(0));
    drive(1'b1, 16'd1, 1'b1, 64'd1000);
    check("abort no done 3", 128'(done_a),  128'(0));
    check("abort no stray",  128'(stray_a), 128'(0));
    drive(1'b0, 16'd0, 1'b1, 64'd7);
    check("restart done",    128'(done_a),    128'(1));
    check("restart acc_out", 128'(acc_out_a), 128'(7));
    drive(1'b0, 16'd0, 1'b0, 64'd0);
    check("idle no stray",   128'(stray_a), 128'(0));
    drive(1'b0, 16'd0, 1'b1, 64'd55);
    check("stray set",       128'(stray_a),   128'(1));
    check("stray discarded", 128'(acc_out_a), 128'(7));
    drive(1'b0, 16'd0, 1'b0, 64'd0);

    // Reset mid-run, with start asserted alongside reset.
    drive(1'b1, 16'd4, 1'b0, 64'd0);
    drive(1'b0, 16'd0, 1'b1, 64'd5);
    drive(1'b0, 16'd0, 1'b1, 64'd6);
    reset = 1'b1;
    drive(1'b1, 16'd2, 1'b1, 64'd8);
    reset = 1'b0;
    check("rst acc_out",  128'(acc_out_a), 128'(0));
    check("rst busy",     128'(busy_a),    128'(0));
    check("rst done",     128'(done_a),    128'(0));
    check("rst overflow", 128'(ovf_a),     128'(0));
    check("rst stray",    128'(stray_a),   128'(0));
    drive(1'b1, 16'd1, 1'b0, 64'd0);
    drive(1'b0, 16'd0, 1'b1, 64'd9);
    check("fresh done",    128'(done_a),    128'(1));
    check("fresh acc_out", 128'(acc_out_a), 128'(9));
    drive(1'b0, 16'd0, 1'b0, 64'd0);
    drive(1'b0, 16'd0, 1'b0, 64'd0);

    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end

endmodule

// File: doc/mac_accumulator.md
# mac_accumulator

Downstream consumer of the 32x32 pipelined multiplier in the systolic array processing element. Takes one 64-bit unsigned product per valid cycle, sums exactly `k_len` of them into a wide accumulator, then presents the dot-product result with a one-cycle done pulse. Sits between the multiplier's `result`/`done` outputs and the PE's result-drain path.

## Interface
- `ACC_W`, default 80: accumulator width in bits; must be ≥ 64.
- `K_W`, default 16: width of the product-count field.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: single-cycle command that loads `k_len`, clears the accumulator and the sticky flags, and enters ACCUM.
- `k_len` in K_W: number of products to sum; sampled only on `start`.
- `product` in 64: unsigned multiplier result.
- `prod_valid` in 1: qualifies `product`; driven by the multiplier's `done`.
- `acc_out` out ACC_W: final sum; holds its value from `acc_done` until the next `start`.
- `acc_done` out 1: one-cycle pulse; `acc_out` is valid on this cycle.
- `busy` out 1: high while in ACCUM.
- `overflow` out 1: sticky; set if any addition carries out of `ACC_W`.
- `stray` out 1: sticky; set if `prod_valid` is high while not in ACCUM.

## Operation
- States: IDLE, ACCUM, DONE. Encoding is 2 bits.
- IDLE → ACCUM on `start` with `k_len` != 0. Same cycle: `acc` ← 0, `remaining` ← `k_len`, `overflow`/`stray` ← 0.
- IDLE → DONE on `start` with `k_len` == 0. `acc` ← 0, giving a result of 0.
- ACCUM, each cycle with `prod_valid`=1:
  - `acc` ← (`acc` + zero-extended `product`) mod 2^ACC_W.
  - `remaining` ← `remaining` − 1.
  - Carry out of the top bit sets `overflow`.
- ACCUM → DONE when a product is accepted with `remaining` == 1.
- DONE → IDLE unconditionally after one cycle. `acc_done` = 1 only in DONE.
- `start` while in ACCUM or DONE aborts the current run and restarts exactly as from IDLE. No `acc_done` is produced for the aborted run.
- `prod_valid` on the same cycle as `start` is ignored. Counting begins the cycle after `start`.
- `prod_valid` in IDLE or DONE (without `start`): the product is discarded and `stray` is set.
- Gaps in `prod_valid` during ACCUM are allowed. The block waits indefinitely; there is no timeout.
- Arithmetic is unsigned only; there is no saturation, only wrap plus the `overflow` flag.

## Timing
- Reset values: state=IDLE, `acc`=0, `acc_out`=0, `acc_done`=0, `busy`=0, `overflow`=0, `stray`=0, `remaining`=0.
- `reset` overrides `start` and any run in progress; partial sums are discarded.
- Latency: `acc_done` is high exactly 1 cycle after the edge on which the k-th product is accepted.
  - Back-to-back `prod_valid`: `start` at cycle 0, products at cycles 1..K, `acc_done` at cycle K+1.
- `k_len`=0: `acc_done` at cycle 1 after `start`, with `acc_out`=0.
- `busy` is registered. It is high from the cycle after `start` until the cycle `acc_done` rises.
- `acc_out` is the registered accumulator, stable and readable while `acc_done` is high and afterwards.
- No combinational path from `product` or `prod_valid` to any output.
- Maximum throughput: one product per clock.

## Structure
- Shared package `pe_pkg`:
  - State constants `ST_IDLE`=0, `ST_ACCUM`=1, `ST_DONE`=2.
  - Default `ACC_W` and `K_W` localparams.
- One sub-module, `k_counter` (parameter `K_W`):
  - Load on `start`, decrement on accepted product.
  - Outputs `last` = (`remaining` == 1) and `zero`.
- Adder and FSM stay in the top level.

## Test plan
- Basic sum: `start`, `k_len`=4; products 1, 2, 3, 4 on consecutive cycles → `acc_done` at cycle 5, `acc_out`=10, `overflow`=0.
- Gapped input: `k_len`=3; products 0xFFFF_FFFF_FFFF_FFFF at cycles 1, 4 and 9 → `acc_done` at cycle 10, `acc_out`=0x2_FFFF_FFFF_FFFF_FFFD, `busy` high for cycles 1..9.
- Overflow: `ACC_W`=64, `k_len`=2; products 2^63 and 2^63 → `acc_out`=0, `overflow`=1 while `acc_done` is high.
- Zero length: `start` with `k_len`=0 and no products → `acc_done` at cycle 1, `acc_out`=0, `busy` never high.
- Abort and stray:
  - `k_len`=5, 2 products, then `start` with `k_len`=1 → no `acc_done` for the first run.
  - Product 7 next → `acc_out`=7.
  - Subsequent `prod_valid` in IDLE → `stray`=1.
- Reset mid-run: `reset` after 2 of 4 products → all outputs return to their reset values the next cycle; a fresh `start` with `k_len`=1 and product 9 gives `acc_out`=9.
